// File: rtl/mem_wb_stage.sv
// Memory stage and MEM/WB pipeline register: issues the data-cache request for the
// instruction leaving EX/MEM, holds it until dhit, then hands the result set to write-back.
module mem_wb_stage #(
    parameter int DW = 32,
    parameter int RW = 5,
    parameter int CW = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          pipe_en,
    input  logic          m_valid,
    input  logic          m_dREN,
    input  logic          m_dWEN,
    input  logic [DW-1:0] m_addr,
    input  logic [DW-1:0] m_store,
    input  logic [DW-1:0] m_aluout,
    input  logic [DW-1:0] m_npc,
    input  logic [RW-1:0] m_wreg,
    input  logic          m_regwen,
    input  logic          m_jal,
    input  logic          m_ld,
    input  logic          m_halt,
    input  logic          dhit,
    input  logic [DW-1:0] dmemload,
    output logic          dmemREN,
    output logic          dmemWEN,
    output logic [DW-1:0] dmemaddr,
    output logic [DW-1:0] dmemstore,
    output logic          mem_stall,
    output logic          wb_valid,
    output logic          wb_Reg_Wen,
    output logic [RW-1:0] wb_wreg,
    output logic [DW-1:0] wb_memReg,
    output logic [DW-1:0] wb_ldData,
    output logic [DW-1:0] wb_npc,
    output logic          wb_jaltype,
    output logic          wb_ldtype,
    output logic          wb_halt,
    output logic [CW-1:0] dstall_cnt
);

    typedef enum logic {PASS, WAIT} state_t;
    state_t state;

    logic [DW-1:0] hold_addr, hold_store, hold_aluout, hold_npc;
    logic [RW-1:0] hold_wreg;
    logic          hold_ren, hold_wen, hold_regwen, hold_jal, hold_ld, hold_halt;
    logic          mem_op;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    assign mem_op = m_valid & (m_dREN | m_dWEN) & ~wb_halt;

    // Request stage: live from EX/MEM in PASS, frozen from the hold register in WAIT
    always_comb begin
        dmemREN   = 1'b0;
        dmemWEN   = 1'b0;
        dmemaddr  = '0;
        dmemstore = '0;
        mem_stall = 1'b0;
        if (state == WAIT) begin
            dmemREN   = hold_ren;
            dmemWEN   = hold_wen;
            dmemaddr  = hold_addr;
            dmemstore = hold_store;
            mem_stall = ~dhit;
        end else if (mem_op) begin
            dmemREN   = m_dREN;
            dmemWEN   = m_dWEN & ~m_dREN;
            dmemaddr  = m_addr;
            dmemstore = m_store;
            mem_stall = ~dhit;
        end
    end

    // MEM/WB register boundary
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= PASS;
            wb_valid   <= 1'b0;
            wb_Reg_Wen <= 1'b0;
            wb_wreg    <= '0;
            wb_memReg  <= '0;
            wb_ldData  <= '0;
            wb_npc     <= '0;
            wb_jaltype <= 1'b0;
            wb_ldtype  <= 1'b0;
            wb_halt    <= 1'b0;
            dstall_cnt <= '0;
        end else begin
            // Bubble unless a branch below commits an instruction
            wb_valid   <= 1'b0;
            wb_Reg_Wen <= 1'b0;
            case (state)
                PASS: begin
                    if (!wb_halt) begin
                        if (mem_op && dhit) begin
                            wb_valid   <= 1'b1;
                            wb_Reg_Wen <= m_regwen;
                            wb_wreg    <= m_wreg;
                            wb_memReg  <= m_aluout;
                            wb_ldData  <= dmemload;
                            wb_npc     <= m_npc;
                            wb_jaltype <= m_jal;
                            wb_ldtype  <= m_ld;
                            wb_halt    <= m_halt;
                        end else if (mem_op) begin
                            hold_addr   <= m_addr;
                            hold_store  <= m_store;
                            hold_ren    <= m_dREN;
                            hold_wen    <= m_dWEN & ~m_dREN;
                            hold_aluout <= m_aluout;
                            hold_npc    <= m_npc;
                            hold_wreg   <= m_wreg;
                            hold_regwen <= m_regwen;
                            hold_jal    <= m_jal;
                            hold_ld     <= m_ld;
                            hold_halt   <= m_halt;
                            state       <= WAIT;
                        end else if (pipe_en) begin
                            wb_valid   <= m_valid;
                            wb_Reg_Wen <= m_regwen & m_valid;
                            wb_wreg    <= m_wreg;
                            wb_memReg  <= m_aluout;
                            wb_npc     <= m_npc;
                            wb_jaltype <= m_jal;
                            wb_ldtype  <= m_ld;
                            wb_halt    <= m_valid & m_halt;
                        end
                    end
                end
                WAIT: begin
                    dstall_cnt <= sat_inc(dstall_cnt);
                    if (dhit) begin
                        wb_valid   <= 1'b1;
                        wb_Reg_Wen <= hold_regwen;
                        wb_wreg    <= hold_wreg;
                        wb_memReg  <= hold_aluout;
                        wb_ldData  <= dmemload;
                        wb_npc     <= hold_npc;
                        wb_jaltype <= hold_jal;
                        wb_ldtype  <= hold_ld;
                        wb_halt    <= hold_halt;
                        state      <= PASS;
                    end
                end
                default: state <= PASS;
            endcase
        end
    end

endmodule
